// File: rtl/pipeline_pkg.sv
// Shared constants and fetch FSM encoding for the pipelined RAT core.
package pipeline_pkg;

  localparam int PC_WIDTH        = 10;
  localparam int INSTR_WIDTH     = 18;
  localparam int STALL_CNT_WIDTH = 16;

  localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 10'h000;
  localparam logic [PC_WIDTH-1:0] INT_VECTOR   = 10'h3FF;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    REPLAY   = 2'd1,
    REDIRECT = 2'd2
  } FetchState;

endpackage

// File: rtl/fetch_latch.sv
// Fetch/decode pipeline latch: instruction, its PC and a valid bit.
module fetch_latch
  import pipeline_pkg::*;
#(
  parameter int PC_W    = PC_WIDTH,
  parameter int INSTR_W = INSTR_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               valid_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;

  // Flush only clears valid; the stale payload is kept rather than reloaded.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      instr_d = data_i;
      pc_d    = pc_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipeline_fetch.sv
// Fetch stage: PC register, synchronous imem addressing with stall replay,
// wrong-path squash after redirects and a saturating stall-cycle counter.
module pipeline_fetch
  import pipeline_pkg::*;
#(
  parameter int                     PC_WIDTH        = pipeline_pkg::PC_WIDTH,
  parameter int                     INSTR_WIDTH     = pipeline_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR    = pipeline_pkg::RESET_VECTOR,
  parameter logic [PC_WIDTH-1:0]    INT_VECTOR      = pipeline_pkg::INT_VECTOR,
  parameter int                     STALL_CNT_WIDTH = pipeline_pkg::STALL_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       pc_reset,
  input  logic                       pc_inc,
  input  logic                       pc_load,
  input  logic [PC_WIDTH-1:0]        pc_load_addr,
  input  logic                       interrupt,
  input  logic                       fetch_latch_stall,
  input  logic                       imem_addr_mux,
  input  logic                       dec_nop,
  output logic [PC_WIDTH-1:0]        imem_addr,
  input  logic [INSTR_WIDTH-1:0]     imem_data,
  output logic [INSTR_WIDTH-1:0]     fd_instr,
  output logic [PC_WIDTH-1:0]        fd_pc,
  output logic                       fd_valid,
  output logic [PC_WIDTH-1:0]        int_ret_pc,
  output logic [PC_WIDTH-1:0]        pc,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  logic [PC_WIDTH-1:0]        pc_q, pc_d;
  logic [PC_WIDTH-1:0]        addr_q;
  logic                       addr_valid_q;
  logic [PC_WIDTH-1:0]        int_ret_q, int_ret_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  FetchState                  state_q, state_d;
  logic                       flush;
  logic                       fd_valid_q;

  assign flush     = pc_reset | interrupt | pc_load;
  assign imem_addr = imem_addr_mux ? addr_q : pc_q;

  always_comb begin
    pc_d      = pc_q;
    int_ret_d = int_ret_q;
    if (pc_reset) begin
      pc_d = RESET_VECTOR;
    end else if (interrupt) begin
      pc_d      = INT_VECTOR;
      int_ret_d = pc_q;
    end else if (pc_load) begin
      pc_d = pc_load_addr;
    end else if (!fetch_latch_stall && pc_inc) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (flush)                  state_d = REDIRECT;
        else if (fetch_latch_stall) state_d = REPLAY;
      end
      REPLAY: begin
        if (flush)                   state_d = REDIRECT;
        else if (!fetch_latch_stall) state_d = FETCH;
      end
      REDIRECT: begin
        if (flush)                  state_d = REDIRECT;
        else if (fetch_latch_stall) state_d = REPLAY;
        else                        state_d = FETCH;
      end
      default: state_d = REDIRECT;
    endcase
  end

  // Every cycle that lands in REPLAY is a stalled cycle, entry cycle included.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_d == REPLAY && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_VECTOR;
      addr_q       <= RESET_VECTOR;
      addr_valid_q <= 1'b0;
      int_ret_q    <= '0;
      stall_cnt_q  <= '0;
      state_q      <= REDIRECT;
    end else begin
      pc_q         <= pc_d;
      addr_q       <= imem_addr;
      addr_valid_q <= !flush;
      int_ret_q    <= int_ret_d;
      stall_cnt_q  <= stall_cnt_d;
      state_q      <= state_d;
    end
  end

  fetch_latch #(
    .PC_W    (PC_WIDTH),
    .INSTR_W (INSTR_WIDTH)
  ) u_fetch_latch (
    .clk     (clk),
    .rst_n   (reset_n),
    .flush_i (flush),
    .stall_i (fetch_latch_stall),
    .data_i  (imem_data),
    .pc_i    (addr_q),
    .valid_i (addr_valid_q),
    .instr_o (fd_instr),
    .pc_o    (fd_pc),
    .valid_o (fd_valid_q)
  );

  assign fd_valid     = fd_valid_q & ~dec_nop;
  assign int_ret_pc   = int_ret_q;
  assign pc           = pc_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_fetch.sv
// Directed bench for pipeline_fetch: expected fetch stream in a queue,
// popped by a negedge monitor, plus directed register checks.
module tb_pipeline_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_reset, pc_inc, pc_load, interrupt;
  logic [9:0]  pc_load_addr;
  logic        fetch_latch_stall, imem_addr_mux, dec_nop;
  logic [9:0]  imem_addr;
  logic [17:0] imem_data;
  logic [17:0] fd_instr;
  logic [9:0]  fd_pc;
  logic        fd_valid;
  logic [9:0]  int_ret_pc;
  logic [9:0]  pc;
  logic [15:0] stall_cycles;

  logic [27:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic        held   = 1'b0;

  pipeline_fetch dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pc_reset          (pc_reset),
    .pc_inc            (pc_inc),
    .pc_load           (pc_load),
    .pc_load_addr      (pc_load_addr),
    .interrupt         (interrupt),
    .fetch_latch_stall (fetch_latch_stall),
    .imem_addr_mux     (imem_addr_mux),
    .dec_nop           (dec_nop),
    .imem_addr         (imem_addr),
    .imem_data         (imem_data),
    .fd_instr          (fd_instr),
    .fd_pc             (fd_pc),
    .fd_valid          (fd_valid),
    .int_ret_pc        (int_ret_pc),
    .pc                (pc),
    .stall_cycles      (stall_cycles)
  );

  // clock / synchronous memory model: word = address + 0x100
  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_data <= {8'h00, imem_addr} + 18'h100;
    held      <= fetch_latch_stall & ~(pc_reset | interrupt | pc_load);
  end

  // scoreboard monitor: a new word is presented when the latch was not held
  always @(negedge clk) begin
    logic [27:0] e;
    if (reset_n === 1'b1 && fd_valid === 1'b1 && !held) begin
      n_vec = n_vec + 1;
      if (exp_q.size() == 0) begin
        n_miss = n_miss + 1;
        $display("FAIL stream: unexpected word pc=0x%0h instr=0x%0h, queue empty", fd_pc, fd_instr);
      end else begin
        e = exp_q.pop_front();
        if ({fd_pc, fd_instr} !== e) begin
          n_miss = n_miss + 1;
          $display("FAIL stream: got pc=0x%0h instr=0x%0h, expected pc=0x%0h instr=0x%0h",
                   fd_pc, fd_instr, e[27:18], e[17:0]);
        end
      end
    end
  end

  task automatic push(input logic [9:0] a);
    logic [17:0] ins;
    ins = {8'h00, a} + 18'h100;
    exp_q.push_back({a, ins});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    pc_reset = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; interrupt = 1'b0;
    pc_load_addr = '0; fetch_latch_stall = 1'b0; imem_addr_mux = 1'b0; dec_nop = 1'b0;
    repeat (2) tick();
    chk("rst_pc", pc, 10'h000);
    chk("rst_fd_valid", fd_valid, 1'b0);
    chk("rst_fd_pc", fd_pc, 10'h000);
    chk("rst_stall", stall_cycles, 16'd0);
    chk("rst_int_ret", int_ret_pc, 10'h000);

    // straight-line fetch
    push(10'd0); push(10'd1); push(10'd2); push(10'd3);
    reset_n = 1'b1; pc_inc = 1'b1;
    tick();
    chk("edge1_pc", pc, 10'd1);
    chk("edge1_valid", fd_valid, 1'b0);
    tick();
    chk("edge2_valid", fd_valid, 1'b1);
    repeat (3) tick();
    chk("pre_stall_pc", pc, 10'd5);

    // stall replay
    fetch_latch_stall = 1'b1; imem_addr_mux = 1'b1;
    #1 chk("replay_addr", imem_addr, 10'd4);
    repeat (3) tick();
    chk("stall_pc", pc, 10'd5);
    chk("stall_addr", imem_addr, 10'd4);
    chk("stall_fd_pc", fd_pc, 10'd3);
    chk("stall_cnt3", stall_cycles, 16'd3);
    fetch_latch_stall = 1'b0; imem_addr_mux = 1'b0;
    push(10'd4); push(10'd5); push(10'd6);
    repeat (3) tick();
    chk("post_stall_pc", pc, 10'd8);
    chk("post_stall_fd_pc", fd_pc, 10'd6);

    // branch redirect
    pc_load = 1'b1; pc_load_addr = 10'h040;
    push(10'h040); push(10'h041);
    tick();
    chk("br_pc", pc, 10'h040);
    chk("br_valid0", fd_valid, 1'b0);
    pc_load = 1'b0;
    tick();
    chk("br_valid1", fd_valid, 1'b0);
    tick();
    chk("br_valid2", fd_valid, 1'b1);
    chk("br_fd_pc", fd_pc, 10'h040);
    tick();
    chk("br_pc_adv", pc, 10'h043);

    // interrupt colliding with a load
    pc_load = 1'b1; pc_load_addr = 10'h123;
    tick();
    chk("ld_123", pc, 10'h123);
    interrupt = 1'b1; pc_load_addr = 10'h050;
    tick();
    chk("int_pc", pc, 10'h3FF);
    chk("int_ret", int_ret_pc, 10'h123);
    interrupt = 1'b0; pc_load = 1'b0;
    push(10'h3FF); push(10'h000); push(10'h003);
    tick();
    chk("wrap_pc", pc, 10'h000);
    repeat (2) tick();
    chk("int_fd_pc", fd_pc, 10'h000);

    // dec_nop masks without freezing the latch
    tick();
    dec_nop = 1'b1;
    #1 chk("nop_valid", fd_valid, 1'b0);
    chk("nop_fd_pc1", fd_pc, 10'd1);
    tick();
    chk("nop_fd_pc2", fd_pc, 10'd2);
    chk("nop_valid2", fd_valid, 1'b0);
    tick();
    dec_nop = 1'b0;
    #1 chk("unnop_valid", fd_valid, 1'b1);
    chk("unnop_fd_pc", fd_pc, 10'd3);
    chk("unnop_pc", pc, 10'd5);

    // async reset in the middle of a stall
    fetch_latch_stall = 1'b1; imem_addr_mux = 1'b1;
    repeat (2) tick();
    chk("stall_cnt5", stall_cycles, 16'd5);
    chk("stall2_pc", pc, 10'd5);
    #1 reset_n = 1'b0;
    #1 chk("arst_pc", pc, 10'h000);
    chk("arst_valid", fd_valid, 1'b0);
    chk("arst_stall", stall_cycles, 16'd0);
    chk("arst_addr", imem_addr, 10'h000);
    #1 reset_n = 1'b1;
    fetch_latch_stall = 1'b0; imem_addr_mux = 1'b0;
    push(10'd0); push(10'd1); push(10'd2);
    tick();
    chk("restart_pc", pc, 10'd1);
    chk("restart_valid0", fd_valid, 1'b0);
    tick();
    chk("restart_valid1", fd_valid, 1'b1);
    chk("restart_fd_pc", fd_pc, 10'd0);
    repeat (2) tick();
    @(negedge clk);
    #1 chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
